counter_snapshot_fifo: RTL and testbench

//   Downstream consumer of the dual 64-bit counter block (Output0/Output1).
//   - On each Sample pulse, captures the pair {Cnt0, Cnt1} into a small FIFO.
//   - Drains each entry as a serial stream of OUT_W-bit beats over a

---
 rtl/counter_snapshot_fifo.sv | 149 ++++++++++++++
 tb/tb_counter_snapshot_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/counter_snapshot_fifo.sv
// Captures {Cnt1, Cnt0} snapshots into a small FIFO and drains each entry
// as BEATS serial OUT_W-bit beats over a valid/ready handshake.
module counter_snapshot_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int OUT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Cnt0,
    input  logic [WIDTH-1:0] Cnt1,
    input  logic             Sample,
    output logic [OUT_W-1:0] DOut,
    output logic             DValid,
    input  logic             DReady,
    output logic             DLast,
    output logic             Full,
    output logic             Empty,
    output logic [7:0]       Drops
);

    localparam int BEATS  = 2 * WIDTH / OUT_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [2*WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;
    logic [BEAT_W-1:0]  beat_r;
    logic [BEAT_W-1:0]  beat_s;
    logic [7:0]         drops_r;
    logic               xfer_s;
    logic               last_xfer_s;
    logic               push_s;
    logic               drop_s;
    logic [2*WIDTH-1:0] head_s;
    logic [OUT_W-1:0]   beat_data_s [BEATS];

    // Handshake, push/drop decision and next occupancy.
    // A full FIFO still accepts a sample when the head's final beat leaves on the same edge.
    always_comb begin
        xfer_s      = (state_r == SEND) && DReady;
        last_xfer_s = xfer_s && (beat_r == LAST_BEAT);
        push_s      = Sample && ((count_r != DEPTH_C) || last_xfer_s);
        drop_s      = Sample && !push_s;
        count_s     = count_r;
        if (push_s && !last_xfer_s) begin
            count_s = count_r + CNT_W'(1);
        end else if (!push_s && last_xfer_s) begin
            count_s = count_r - CNT_W'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Drain FSM next state and beat index.
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        case (state_r)
            IDLE: begin
                beat_s = BEAT_ZERO;
                if (push_s) begin
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (last_xfer_s) begin
                    beat_s  = BEAT_ZERO;
                    state_s = (count_s == CNT_ZERO) ? IDLE : SEND;
                end else if (xfer_s) begin
                    beat_s  = beat_r + BEAT_W'(1);
                    state_s = SEND;
                end else begin
                    beat_s  = beat_r;
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
                beat_s  = BEAT_ZERO;
            end
        endcase
    end

    // Control state: FSM, pointers, occupancy and saturating drop counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= IDLE;
            beat_r   <= BEAT_ZERO;
            count_r  <= CNT_ZERO;
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            drops_r  <= 8'h00;
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
            count_r <= count_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (last_xfer_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (drop_s && (drops_r != 8'hFF)) begin
                drops_r <= drops_r + 8'h01;
            end
        end
    end

    // Snapshot storage; contents need no reset because pointers gate visibility.
    always_ff @(posedge Clk) begin
        if (!Reset && push_s) begin
            mem_r[wr_ptr_r] <= {Cnt1, Cnt0};
        end
    end

    // Split the head entry into beats, Cnt0 low half first.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        for (int i = 0; i < BEATS; i++) begin
            beat_data_s[i] = head_s[i*OUT_W +: OUT_W];
        end
    end

    assign DValid = (state_r == SEND);
    assign DOut   = DValid ? beat_data_s[beat_r] : {OUT_W{1'b0}};
    assign DLast  = DValid && (beat_r == LAST_BEAT);
    assign Full   = (count_r == DEPTH_C);
    assign Empty  = (count_r == CNT_ZERO);
    assign Drops  = drops_r;

endmodule

// File: tb/tb_counter_snapshot_fifo.sv
// Bench for counter_snapshot_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_counter_snapshot_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 64;
    localparam int OUT_W = 32;
    localparam int BEATS = 2 * WIDTH / OUT_W;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [WIDTH-1:0] Cnt0;
    logic [WIDTH-1:0] Cnt1;
    logic             Sample;
    logic [OUT_W-1:0] DOut;
    logic             DValid;
    logic             DReady;
    logic             DLast;
    logic             Full;
    logic             Empty;
    logic [7:0]       Drops;

    counter_snapshot_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Cnt0(Cnt0), .Cnt1(Cnt1), .Sample(Sample),
        .DOut(DOut), .DValid(DValid), .DReady(DReady), .DLast(DLast),
        .Full(Full), .Empty(Empty), .Drops(Drops)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of snapshots, beat index, drop count.
    logic [2*WIDTH-1:0] mq [$];
    int mk = 0;
    int mdrops = 0;
    logic [OUT_W-1:0] heads [$];
    int nbeats;

    typedef struct {
        logic        rst;
        logic        smp;
        logic [63:0] c0;
        logic [63:0] c1;
        logic        rdy;
        logic        v;
        logic        l;
        logic        f;
        logic        e;
        logic [7:0]  dr;
        logic [31:0] d;
    } vec_t;

    vec_t tbl [7];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [43:0] model_outs();
        logic [2*WIDTH-1:0] h;
        logic [OUT_W-1:0]   d;
        logic               v;
        logic               l;
        d = '0;
        v = 1'b0;
        l = 1'b0;
        if (mq.size() > 0) begin
            h = mq[0];
            d = h[mk*OUT_W +: OUT_W];
            v = 1'b1;
            l = (mk == BEATS - 1);
        end
        return {v, l, (mq.size() == DEPTH), (mq.size() == 0), 8'(mdrops), d};
    endfunction

    task automatic cycle(input logic rst, input logic smp, input logic [63:0] c0,
                         input logic [63:0] c1, input logic rdy);
        logic v;
        logic xfer;
        logic last;
        logic acc;
        Reset  = rst;
        Sample = smp;
        Cnt0   = c0;
        Cnt1   = c1;
        DReady = rdy;
        if (rst) begin
            mq.delete();
            mk = 0;
            mdrops = 0;
        end else begin
            v    = (mq.size() > 0);
            xfer = v && rdy;
            last = xfer && (mk == BEATS - 1);
            acc  = smp && ((mq.size() < DEPTH) || last);
            if (last) begin
                void'(mq.pop_front());
                mk = 0;
            end else if (xfer) begin
                mk++;
            end
            if (acc) mq.push_back({c1, c0});
            else if (smp && mdrops < 255) mdrops++;
        end
        @(posedge Clk);
        #1;
        check("model", {DValid, DLast, Full, Empty, Drops, DOut}, model_outs());
    endtask

    task automatic drain(input int maxc);
        heads.delete();
        nbeats = 0;
        for (int c = 0; c < maxc && DValid; c++) begin
            if (nbeats % BEATS == 0) heads.push_back(DOut);
            cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
            nbeats++;
        end
        check("drain_empty", Empty, 1'b1);
    endtask

    initial begin
        //            rst   smp   c0                 c1     rdy   v     l     f     e     drops  dout
        tbl[0] = '{1'b1, 1'b0, 64'h0,            64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 64'h0,            64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 64'h1_0000_0002,  64'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h2};
        tbl[3] = '{1'b0, 1'b0, 64'h0,            64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h1};
        tbl[4] = '{1'b0, 1'b0, 64'h0,            64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h3};
        tbl[5] = '{1'b0, 1'b0, 64'h0,            64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 64'h0,            64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0};

        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].rst, tbl[i].smp, tbl[i].c0, tbl[i].c1, tbl[i].rdy);
            check($sformatf("vec%0d", i), {DValid, DLast, Full, Empty, Drops, DOut},
                  {tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].e, tbl[i].dr, tbl[i].d});
        end

        // Overflow while stalled: four accepted, two dropped, drained in order.
        for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, 64'(i), 64'(100 + i), 1'b0);
        check("t3_full", Full, 1'b1);
        check("t3_drops", Drops, 8'd2);
        drain(40);
        check("t3_beats", nbeats, 16);
        check("t3_nheads", heads.size(), 4);
        for (int i = 0; i < heads.size() && i < 4; i++)
            check($sformatf("t3_head%0d", i), heads[i], 32'(i + 1));

        // Sample accepted when full on the same edge as the final-beat transfer.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 64'(10 + i), 64'(200 + i), 1'b0);
        check("t4_full_pre", Full, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
        check("t4_last_pending", DLast, 1'b1);
        cycle(1'b0, 1'b1, 64'd20, 64'd220, 1'b1);
        check("t4_full_post", Full, 1'b1);
        check("t4_drops", Drops, 8'd2);
        check("t4_newhead", DOut, 32'd11);
        drain(40);
        check("t4_nheads", heads.size(), 4);
        if (heads.size() == 4) check("t4_tail", heads[3], 32'd20);

        // Reset in the middle of an entry.
        cycle(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
        cycle(1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
        check("t5_beat0", DOut, 32'hCCCC_DDDD);
        cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
        check("t5_beat2", {DLast, DOut}, {1'b0, 32'h3333_4444});
        cycle(1'b1, 1'b0, 64'h0, 64'h0, 1'b1);
        check("t5_reset", {DValid, Empty, DOut}, {1'b0, 1'b1, 32'h0});
        cycle(1'b0, 1'b1, 64'h5, 64'h6, 1'b0);
        check("t5_restart", {DValid, DLast, DOut}, {1'b1, 1'b0, 32'h5});
        cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
        check("t5_beat1", DOut, 32'h0);

        // Drop counter saturation.
        for (int i = 0; i < 303; i++) cycle(1'b0, 1'b1, 64'(i), 64'(i), 1'b0);
        check("t6_drops_sat", Drops, 8'd255);
        check("t6_full", Full, 1'b1);

        // Randomized traffic against the model.
        cycle(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4),
                  {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
